// File: rtl/serial_alu.sv
// Digit-serial ALU: operands latched on start, DIGIT bits processed per clock LSB first,
// with the carry held between digits; result and flags are published on completion.
module serial_alu #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       ALUop,
  input  logic [WIDTH-1:0] r2,
  input  logic [WIDTH-1:0] r3,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] r1,
  output logic             c_out,
  output logic             overflow,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_sh, b_sh, res_w;
  logic [CW-1:0]    cnt;
  logic             carry;

  logic [DIGIT-1:0]       a_dig, b_dig, b_eff, dres;
  logic [DIGIT:0]         sum;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic [WIDTH-1:0]       res_next, final_r1;
  logic                   inv_b, arith, carry_msb, ovf;

  // Operands shift right each digit; the result digit enters at the top so that
  // after N digits the working register holds the full result in place.
  always_comb begin
    a_dig     = a_sh[DIGIT-1:0];
    b_dig     = b_sh[DIGIT-1:0];
    inv_b     = (op_q == OP_SUB) || (op_q == OP_SLT);
    arith     = (op_q == OP_ADD) || (op_q == OP_SUB);
    b_eff     = inv_b ? ~b_dig : b_dig;
    sum       = {1'b0, a_dig} + {1'b0, b_eff} + {{DIGIT{1'b0}}, carry};
    dres      = '0;
    case (op_q)
      OP_AND:  dres = a_dig & b_dig;
      OP_OR:   dres = a_dig | b_dig;
      OP_XOR:  dres = a_dig ^ b_dig;
      OP_NOT:  dres = ~a_dig;
      OP_MOV:  dres = a_dig;
      default: dres = sum[DIGIT-1:0];
    endcase
    res_cat   = {dres, res_w};
    res_next  = res_cat[WIDTH+DIGIT-1:DIGIT];
    carry_msb = a_dig[DIGIT-1] ^ b_eff[DIGIT-1] ^ sum[DIGIT-1];
    ovf       = carry_msb ^ sum[DIGIT];
    final_r1  = res_next;
    if (op_q == OP_SLT) final_r1 = WIDTH'(sum[DIGIT-1] ^ ovf);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_q     <= OP_AND;
      a_sh     <= '0;
      b_sh     <= '0;
      res_w    <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      r1       <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b1;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            op_q  <= ALUop;
            a_sh  <= r2;
            b_sh  <= r3;
            cnt   <= '0;
            carry <= (ALUop == OP_SUB) || (ALUop == OP_SLT);
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> DIGIT;
          b_sh  <= b_sh >> DIGIT;
          res_w <= res_next;
          carry <= sum[DIGIT];
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            r1       <= final_r1;
            c_out    <= arith ? sum[DIGIT] : 1'b0;
            overflow <= arith ? ovf : 1'b0;
            zero     <= (final_r1 == '0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_alu.sv
// Directed bench for serial_alu: an 8-bit bit-serial instance and an 8-bit
// nibble-serial instance share clock, reset and operand buses.
module tb_serial_alu;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start1, start4;
  logic [2:0] alu_op;
  logic [7:0] r2, r3;

  logic       busy1, done1, c_out1, ovf1, zero1;
  logic [7:0] r1_1;
  logic       busy4, done4, c_out4, ovf4, zero4;
  logic [7:0] r1_4;

  bit         sel4;
  logic       busy_s, done_s, c_out_s, ovf_s, zero_s;
  logic [7:0] r1_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_alu #(.WIDTH(8), .DIGIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .ALUop(alu_op), .r2(r2), .r3(r3),
    .busy(busy1), .done(done1), .r1(r1_1), .c_out(c_out1), .overflow(ovf1), .zero(zero1)
  );

  serial_alu #(.WIDTH(8), .DIGIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .ALUop(alu_op), .r2(r2), .r3(r3),
    .busy(busy4), .done(done4), .r1(r1_4), .c_out(c_out4), .overflow(ovf4), .zero(zero4)
  );

  assign busy_s  = sel4 ? busy4  : busy1;
  assign done_s  = sel4 ? done4  : done1;
  assign r1_s    = sel4 ? r1_4   : r1_1;
  assign c_out_s = sel4 ? c_out4 : c_out1;
  assign ovf_s   = sel4 ? ovf4   : ovf1;
  assign zero_s  = sel4 ? zero4  : zero1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_res(input string tag, input logic [7:0] r1e, input logic ce,
                           input logic oe, input logic ze);
    check({tag, "_r1"},   32'(r1_s),    32'(r1e));
    check({tag, "_cout"}, 32'(c_out_s), 32'(ce));
    check({tag, "_ovf"},  32'(ovf_s),   32'(oe));
    check({tag, "_zero"}, 32'(zero_s),  32'(ze));
  endtask

  // Entered at a falling edge with e0 edges already counted since (and including) the accept edge.
  task automatic finish_op(input int e0, input int n_exp, input string tag);
    int edges;
    edges = e0;
    while (done_s !== 1'b1 && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check({tag, "_lat"}, 32'(edges), 32'(n_exp));
  endtask

  // Called at a falling edge; returns at the falling edge inside the done cycle.
  task automatic do_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                       input int n_exp, input string tag);
    alu_op = o;
    r2     = a;
    r3     = b;
    if (sel4) start4 = 1'b1;
    else      start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    start4 = 1'b0;
    finish_op(1, n_exp, tag);
  endtask

  initial begin
    int dn;
    rst_n  = 1'b0;
    start1 = 1'b0;
    start4 = 1'b0;
    alu_op = OP_AND;
    r2     = 8'h00;
    r3     = 8'h00;
    sel4   = 1'b0;

    #23;
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_done", 32'(done1), 32'd0);
    check_res("rst", 8'h00, 1'b0, 1'b0, 1'b1);
    check("rst_busy4", 32'(busy4), 32'd0);
    check("rst_r1_4",  32'(r1_4),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (10) begin
      @(negedge clk);
      if (done1 || busy1) dn++;
    end
    check("idle_activity", 32'(dn), 32'd0);
    check_res("idle", 8'h00, 1'b0, 1'b0, 1'b1);

    do_op(OP_ADD, 8'h7F, 8'h01, 9, "add_ovf");
    check_res("add_ovf", 8'h80, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("done_pulse", 32'(done1), 32'd0);
    check("hold_r1", 32'(r1_1), 32'h80);

    do_op(OP_SUB, 8'h05, 8'h07, 9, "sub_neg");
    check_res("sub_neg", 8'hFE, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    do_op(OP_SUB, 8'h07, 8'h07, 9, "sub_eq");
    check_res("sub_eq", 8'h00, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    do_op(OP_SLT, 8'h80, 8'h01, 9, "slt_lt");
    check_res("slt_lt", 8'h01, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    do_op(OP_SLT, 8'h01, 8'h80, 9, "slt_ge");
    check_res("slt_ge", 8'h00, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    do_op(OP_ADD, 8'hFF, 8'h01, 9, "add_wrap");
    check_res("add_wrap", 8'h00, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    do_op(OP_AND, 8'hF0, 8'h3C, 9, "and");
    check_res("and", 8'h30, 1'b0, 1'b0, 1'b0);

    // Start pulse in the middle of a run must not disturb the operation.
    @(negedge clk);
    alu_op = OP_ADD; r2 = 8'h10; r3 = 8'h20; start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    check("run_busy", 32'(busy1), 32'd1);
    check("run_hold_r1", 32'(r1_1), 32'h30);
    repeat (2) begin @(posedge clk); @(negedge clk); end
    alu_op = OP_SUB; r2 = 8'hFF; r3 = 8'h0F; start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    r2 = 8'h00; r3 = 8'h00; alu_op = OP_AND;
    finish_op(4, 9, "midrun");
    check_res("midrun", 8'h30, 1'b0, 1'b0, 1'b0);

    // Back-to-back: accepted during the done cycle.
    do_op(OP_ADD, 8'h01, 8'h02, 9, "b2b");
    check_res("b2b", 8'h03, 1'b0, 1'b0, 1'b0);

    // Reset while digit 4 of an add is being processed.
    @(negedge clk);
    alu_op = OP_ADD; r2 = 8'h7F; r3 = 8'h01; start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy1), 32'd0);
    check("arst_done", 32'(done1), 32'd0);
    check_res("arst", 8'h00, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    dn = 0;
    repeat (15) begin
      @(negedge clk);
      if (done1) dn++;
    end
    check("arst_no_done", 32'(dn), 32'd0);
    check("arst_hold_r1", 32'(r1_1), 32'h00);

    sel4 = 1'b1;
    @(negedge clk);
    do_op(OP_ADD, 8'h7F, 8'h01, 3, "d4_add");
    check_res("d4_add", 8'h80, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("d4_done_pulse", 32'(done4), 32'd0);
    do_op(OP_SUB, 8'h80, 8'h01, 3, "d4_sub");
    check_res("d4_sub", 8'h7F, 1'b1, 1'b1, 1'b0);
    do_op(OP_OR, 8'hA0, 8'h05, 3, "d4_or");
    check_res("d4_or", 8'hA5, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    do_op(OP_XOR, 8'hFF, 8'h0F, 3, "d4_xor");
    check_res("d4_xor", 8'hF0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    do_op(OP_NOT, 8'h0F, 8'h55, 3, "d4_not");
    check_res("d4_not", 8'hF0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    do_op(OP_MOV, 8'h5A, 8'hFF, 3, "d4_mov");
    check_res("d4_mov", 8'h5A, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    do_op(OP_SLT, 8'h01, 8'h80, 3, "d4_slt");
    check_res("d4_slt", 8'h00, 1'b0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
